// File: rtl/data_line_reader_pkg.sv
// Shared LC-3b types for the read-side line buffer: word/line/offset/tag widths and FSM states.
package data_line_reader_pkg;

   localparam int unsigned WORD_W   = 16;
   localparam int unsigned LINE_W   = 128;
   localparam int unsigned OFFSET_W = 4;
   localparam int unsigned TAG_W    = 12;

   typedef logic [WORD_W-1:0]   lc3b_word;
   typedef logic [LINE_W-1:0]   lc3b_mem_data;
   typedef logic [OFFSET_W-1:0] lc3b_c_offset;
   typedef logic [TAG_W-1:0]    lc3b_c_tag;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      RESPOND = 2'd2
   } lc3b_rd_state;

   function automatic lc3b_c_tag addr_tag(input lc3b_word addr);
      return addr[WORD_W-1:OFFSET_W];
   endfunction

   function automatic lc3b_c_offset addr_offset(input lc3b_word addr);
      return addr[OFFSET_W-1:0];
   endfunction

endpackage

// File: rtl/data_line_reader_if.sv
// CPU mem_* and physical-memory pmem_* signals of the line reader, bundled as one interface.
interface data_line_reader_if;
   import data_line_reader_pkg::*;

   lc3b_word     mem_address;
   logic         mem_read;
   logic         mem_write;
   lc3b_word     mem_rdata;
   logic         mem_resp;
   lc3b_word     pmem_address;
   logic         pmem_read;
   lc3b_mem_data pmem_rdata;
   logic         pmem_resp;

   modport master (
      output mem_address, mem_read, mem_write, pmem_rdata, pmem_resp,
      input  mem_rdata, mem_resp, pmem_address, pmem_read
   );

   modport slave (
      input  mem_address, mem_read, mem_write, pmem_rdata, pmem_resp,
      output mem_rdata, mem_resp, pmem_address, pmem_read
   );

endinterface

// File: rtl/data_line_reader_line_word_select.sv
// Extracts the 16-bit word addressed by offset[3:1] from a 128-bit line; byte bit is ignored.
module line_word_select
   import data_line_reader_pkg::*;
(
   input  lc3b_mem_data line,
   input  lc3b_c_offset offset,
   output lc3b_word     word
);

   logic [2:0] word_idx;

   assign word_idx = 3'(offset >> 1);
   assign word     = line[{word_idx, 4'b0000} +: WORD_W];

endmodule

// File: rtl/data_line_reader.sv
// One-line read buffer for LC-3b word reads: hits are served from the buffer, misses fetch
// the whole line over pmem, and snooped CPU writes invalidate a matching buffered line.
module data_line_reader
   import data_line_reader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   data_line_reader_if.slave bus
);

   lc3b_rd_state state_q, state_d;
   logic         buf_valid_q, buf_valid_d;
   lc3b_c_tag    buf_tag_q, buf_tag_d;
   lc3b_mem_data buf_line_q, buf_line_d;
   lc3b_word     mem_rdata_q, mem_rdata_d;
   logic         mem_resp_q, mem_resp_d;
   logic         pmem_read_q, pmem_read_d;
   lc3b_word     pmem_address_q, pmem_address_d;

   lc3b_word     buf_word;
   lc3b_word     fetch_word;
   lc3b_c_tag    req_tag;
   logic         tag_match;
   logic         hit;

   line_word_select u_buf_sel (
      .line   (buf_line_q),
      .offset (addr_offset(bus.mem_address)),
      .word   (buf_word)
   );

   line_word_select u_fetch_sel (
      .line   (bus.pmem_rdata),
      .offset (addr_offset(bus.mem_address)),
      .word   (fetch_word)
   );

   assign req_tag   = addr_tag(bus.mem_address);
   assign tag_match = (buf_tag_q == req_tag);
   assign hit       = buf_valid_q && tag_match;

   // Next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      buf_valid_d    = buf_valid_q;
      buf_tag_d      = buf_tag_q;
      buf_line_d     = buf_line_q;
      mem_rdata_d    = mem_rdata_q;
      mem_resp_d     = 1'b0;
      pmem_read_d    = pmem_read_q;
      pmem_address_d = pmem_address_q;

      unique case (state_q)
         IDLE: begin
            pmem_read_d = 1'b0;
            // A write wins over a concurrent read; the read stays pending for a later cycle.
            if (bus.mem_write) begin
               if (tag_match) buf_valid_d = 1'b0;
            end else if (bus.mem_read) begin
               if (hit) begin
                  mem_rdata_d = buf_word;
                  mem_resp_d  = 1'b1;
                  state_d     = RESPOND;
               end else begin
                  pmem_address_d = {req_tag, 4'b0000};
                  pmem_read_d    = 1'b1;
                  state_d        = FETCH;
               end
            end
         end

         FETCH: begin
            if (bus.pmem_resp) begin
               buf_line_d  = bus.pmem_rdata;
               buf_tag_d   = addr_tag(pmem_address_q);
               buf_valid_d = 1'b1;
               mem_rdata_d = fetch_word;
               pmem_read_d = 1'b0;
               if (bus.mem_read) begin
                  mem_resp_d = 1'b1;
                  state_d    = RESPOND;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         RESPOND: begin
            state_d = IDLE;
         end

         default: begin
            state_d     = IDLE;
            pmem_read_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         buf_valid_q    <= 1'b0;
         buf_tag_q      <= '0;
         buf_line_q     <= '0;
         mem_rdata_q    <= '0;
         mem_resp_q     <= 1'b0;
         pmem_read_q    <= 1'b0;
         pmem_address_q <= '0;
      end else begin
         state_q        <= state_d;
         buf_valid_q    <= buf_valid_d;
         buf_tag_q      <= buf_tag_d;
         buf_line_q     <= buf_line_d;
         mem_rdata_q    <= mem_rdata_d;
         mem_resp_q     <= mem_resp_d;
         pmem_read_q    <= pmem_read_d;
         pmem_address_q <= pmem_address_d;
      end
   end

   assign bus.mem_rdata    = mem_rdata_q;
   assign bus.mem_resp     = mem_resp_q;
   assign bus.pmem_read    = pmem_read_q;
   assign bus.pmem_address = pmem_address_q;

endmodule

// File: tb/tb_data_line_reader.sv
// Scenario bench for data_line_reader: expected read words are queued when a read is issued
// and popped when mem_resp is observed.
module tb_data_line_reader;
   import data_line_reader_pkg::*;

   logic clk;
   logic reset;

   data_line_reader_if bus ();

   data_line_reader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int       errors = 0;
   int       checks = 0;
   lc3b_word exp_q[$];

   function automatic lc3b_mem_data make_line(input lc3b_word base);
      lc3b_mem_data l;
      for (int k = 0; k < 8; k++) l[16*k +: 16] = base + 16'(k);
      return l;
   endfunction

   // CPU read with a line-fill responder that answers 3 cycles after pmem_read is seen.
   task automatic cpu_read(input lc3b_word addr, input lc3b_mem_data line,
                           output bit fetched, output lc3b_word faddr, output int cyc,
                           output lc3b_word rd, output bit to);
      fetched = 1'b0; faddr = '0; cyc = 0; rd = '0; to = 1'b0;
      bus.mem_address = addr;
      bus.mem_read    = 1'b1;
      while (!bus.mem_resp) begin
         @(negedge clk); cyc++;
         if (bus.pmem_read && !fetched) begin
            fetched = 1'b1;
            faddr   = bus.pmem_address;
            repeat (2) @(negedge clk);
            cyc += 2;
            bus.pmem_rdata = line;
            bus.pmem_resp  = 1'b1;
            @(negedge clk); cyc++;
            bus.pmem_resp  = 1'b0;
         end
         if (cyc > 50) begin
            to = 1'b1;
            break;
         end
      end
      rd = bus.mem_rdata;
      bus.mem_read = 1'b0;
      @(negedge clk);
   endtask

   task automatic cpu_write(input lc3b_word addr);
      bus.mem_address = addr;
      bus.mem_write   = 1'b1;
      @(negedge clk);
      bus.mem_write   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", bus.mem_rdata); end
      checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b exp=0", bus.mem_resp); end
      checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got=%b exp=0", bus.pmem_read); end
      checks++; if (bus.pmem_address !== 16'h0000) begin errors++; $display("FAIL reset_pmem_addr got=%h exp=0000", bus.pmem_address); end
   endtask

   task automatic test_cold_miss();
      bit f; lc3b_word fa, rd, e; int c; bit to;
      exp_q.push_back(16'h0003);
      cpu_read(16'h1236, make_line(16'h0000), f, fa, c, rd, to);
      e = exp_q.pop_front();
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL miss_timeout got=%b exp=0", to); end
      checks++; if (f !== 1'b1) begin errors++; $display("FAIL miss_fetch got=%b exp=1", f); end
      checks++; if (fa !== 16'h1230) begin errors++; $display("FAIL miss_paddr got=%h exp=1230", fa); end
      checks++; if (c !== 4) begin errors++; $display("FAIL miss_latency got=%0d exp=4", c); end
      checks++; if (rd !== e) begin errors++; $display("FAIL miss_rdata got=%h exp=%h", rd, e); end
   endtask

   task automatic test_hit();
      bit f; lc3b_word fa, rd, e; int c; bit to;
      lc3b_word addrs[3] = '{16'h123E, 16'h1230, 16'h1231};
      lc3b_word words[3] = '{16'h0007, 16'h0000, 16'h0000};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(words[i]);
         cpu_read(addrs[i], make_line(16'hDEAD), f, fa, c, rd, to);
         e = exp_q.pop_front();
         checks++; if (f !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL hit_nofetch[%0d] got fetch=%b to=%b exp=0/0", i, f, to); end
         checks++; if (c !== 1) begin errors++; $display("FAIL hit_latency[%0d] got=%0d exp=1", i, c); end
         checks++; if (rd !== e) begin errors++; $display("FAIL hit_rdata[%0d] got=%h exp=%h", i, rd, e); end
      end
   endtask

   task automatic test_write_snoop();
      bit f; lc3b_word fa, rd, e; int c; bit to;
      cpu_write(16'h1232);
      exp_q.push_back(16'h00A0);
      cpu_read(16'h1230, make_line(16'h00A0), f, fa, c, rd, to);
      e = exp_q.pop_front();
      checks++; if (f !== 1'b1 || fa !== 16'h1230) begin errors++; $display("FAIL snoop_refetch got fetch=%b addr=%h exp=1/1230", f, fa); end
      checks++; if (rd !== e) begin errors++; $display("FAIL snoop_rdata got=%h exp=%h", rd, e); end
      cpu_write(16'h5000);
      exp_q.push_back(16'h00A0);
      cpu_read(16'h1230, make_line(16'hBEEF), f, fa, c, rd, to);
      e = exp_q.pop_front();
      checks++; if (f !== 1'b0 || c !== 1) begin errors++; $display("FAIL snoop_other_hit got fetch=%b lat=%0d exp=0/1", f, c); end
      checks++; if (rd !== e) begin errors++; $display("FAIL snoop_other_rdata got=%h exp=%h", rd, e); end
   endtask

   task automatic test_read_write_same_cycle();
      bit f; lc3b_word fa, rd, e; int c; bit to;
      bus.mem_address = 16'h1234;
      bus.mem_read    = 1'b1;
      bus.mem_write   = 1'b1;
      @(negedge clk);
      bus.mem_write   = 1'b0;
      checks++; if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL rw_write_priority got resp=%b pread=%b exp=0/0", bus.mem_resp, bus.pmem_read); end
      exp_q.push_back(16'h00C2);
      cpu_read(16'h1234, make_line(16'h00C0), f, fa, c, rd, to);
      e = exp_q.pop_front();
      checks++; if (f !== 1'b1 || fa !== 16'h1230 || c !== 4) begin errors++; $display("FAIL rw_miss got fetch=%b addr=%h lat=%0d exp=1/1230/4", f, fa, c); end
      checks++; if (rd !== e) begin errors++; $display("FAIL rw_rdata got=%h exp=%h", rd, e); end
   endtask

   task automatic test_reset_mid_fetch();
      bit f; lc3b_word fa, rd, e; int c; bit to;
      bus.mem_address = 16'h4448;
      bus.mem_read    = 1'b1;
      @(negedge clk);
      checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL rst_fetch_start got=%b exp=1", bus.pmem_read); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.mem_read = 1'b0;
      checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL rst_pmem_drop got=%b exp=0", bus.pmem_read); end
      bus.pmem_rdata = make_line(16'h0F00);
      bus.pmem_resp  = 1'b1;
      @(negedge clk);
      bus.pmem_resp  = 1'b0;
      checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL rst_late_resp got=%b exp=0", bus.mem_resp); end
      @(negedge clk);
      exp_q.push_back(16'h0444);
      cpu_read(16'h4448, make_line(16'h0440), f, fa, c, rd, to);
      e = exp_q.pop_front();
      checks++; if (f !== 1'b1 || fa !== 16'h4440) begin errors++; $display("FAIL rst_refetch got fetch=%b addr=%h exp=1/4440", f, fa); end
      checks++; if (rd !== e) begin errors++; $display("FAIL rst_rdata got=%h exp=%h", rd, e); end
      exp_q.push_back(16'h0314);
      cpu_read(16'h0008, make_line(16'h0310), f, fa, c, rd, to);
      e = exp_q.pop_front();
      checks++; if (f !== 1'b1 || fa !== 16'h0000) begin errors++; $display("FAIL rst_tag0_miss got fetch=%b addr=%h exp=1/0000", f, fa); end
      checks++; if (rd !== e) begin errors++; $display("FAIL rst_tag0_rdata got=%h exp=%h", rd, e); end
   endtask

   task automatic test_read_dropped();
      bit f; lc3b_word fa, rd, e; int c; bit to;
      bus.mem_address = 16'h7772;
      bus.mem_read    = 1'b1;
      @(negedge clk);
      checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h7770) begin errors++; $display("FAIL drop_fetch got pread=%b addr=%h exp=1/7770", bus.pmem_read, bus.pmem_address); end
      bus.mem_read = 1'b0;
      @(negedge clk);
      bus.pmem_rdata = make_line(16'h5550);
      bus.pmem_resp  = 1'b1;
      @(negedge clk);
      bus.pmem_resp  = 1'b0;
      checks++; if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL drop_no_resp got resp=%b pread=%b exp=0/0", bus.mem_resp, bus.pmem_read); end
      @(negedge clk);
      checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL drop_quiet got=%b exp=0", bus.mem_resp); end
      exp_q.push_back(16'h5551);
      cpu_read(16'h7772, make_line(16'hFFF0), f, fa, c, rd, to);
      e = exp_q.pop_front();
      checks++; if (f !== 1'b0 || c !== 1) begin errors++; $display("FAIL drop_hit got fetch=%b lat=%0d exp=0/1", f, c); end
      checks++; if (rd !== e) begin errors++; $display("FAIL drop_rdata got=%h exp=%h", rd, e); end
   endtask

   initial begin
      reset           = 1'b1;
      bus.mem_address = '0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.pmem_rdata  = '0;
      bus.pmem_resp   = 1'b0;
      @(negedge clk);
      test_reset();
      test_cold_miss();
      test_hit();
      test_write_snoop();
      test_read_write_same_cycle();
      test_reset_mid_fetch();
      test_read_dropped();
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
